// File: rtl/q_8_pkg.sv
// Shared constants for the q_8 run-of-ones detector: default run length and
// the named counter states of the default configuration.
package q_8_pkg;

    localparam int Q8_RUN_LEN_DEFAULT = 3;

    // Counter values for RUN_LEN=3; S3 is the detected state.
    typedef enum logic [1:0] {
        S0 = 2'd0,
        S1 = 2'd1,
        S2 = 2'd2,
        S3 = 2'd3
    } q8_state_e;

endpackage

// File: rtl/q_8.sv
// Moore detector for runs of RUN_LEN or more consecutive 1s on din, built as a
// saturating run counter with a registered detect flag.
module q_8
    import q_8_pkg::*;
#(
    parameter int RUN_LEN = Q8_RUN_LEN_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout
);

    localparam int CW = $clog2(RUN_LEN + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(RUN_LEN);

    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_next;

    // Anything other than a clean 1 (including X/Z) takes the else branch and
    // clears the run, so no partial run survives a 0.
    always_comb begin
        cnt_next = '0;
        if (din) begin
            if (cnt == CNT_MAX) begin
                cnt_next = CNT_MAX;
            end else begin
                cnt_next = cnt + CW'(1);
            end
        end
    end

    // dout is loaded from the next count so it rises on the same edge that
    // samples the RUN_LEN-th one, yet still comes straight from a flop.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt  <= '0;
            dout <= 1'b0;
        end else begin
            cnt  <= cnt_next;
            dout <= (cnt_next == CNT_MAX);
        end
    end

endmodule

// File: tb/tb_q_8.sv
// Directed self-checking bench for q_8 with the default RUN_LEN of 3.
module tb_q_8;

    logic clk;
    logic rst;
    logic din;
    logic dout;

    int num_checks;
    int num_fail;

    q_8 dut (
        .clk  (clk),
        .rst  (rst),
        .din  (din),
        .dout (dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change on the falling edge; dout is sampled 1 time unit after the rising edge.
    task automatic drive_edge(input logic d, input logic r);
        @(negedge clk);
        din = d;
        rst = r;
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        drive_edge(1'b0, 1'b1);
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            drive_edge(1'b1, 1'b1);
            num_checks++;
            if (dout !== 1'b0) begin
                num_fail++;
                $display("[TB] FAIL reset_hold edge %0d: dout=%b expected=0", i, dout);
            end
        end
        for (int i = 0; i < 2; i++) begin
            drive_edge(1'b0, 1'b0);
            num_checks++;
            if (dout !== 1'b0) begin
                num_fail++;
                $display("[TB] FAIL reset_release edge %0d: dout=%b expected=0", i, dout);
            end
        end
    endtask

    task automatic test_basic();
        bit seq[3];
        bit expv[3];
        seq  = '{1, 1, 1};
        expv = '{0, 0, 1};
        apply_reset();
        for (int i = 0; i < 3; i++) begin
            drive_edge(seq[i], 1'b0);
            num_checks++;
            if (dout !== expv[i]) begin
                num_fail++;
                $display("[TB] FAIL basic edge %0d: dout=%b expected=%b", i, dout, expv[i]);
            end
        end
    endtask

    task automatic test_overlap();
        bit seq[9];
        bit expv[9];
        seq  = '{1, 1, 1, 1, 0, 1, 1, 1, 0};
        expv = '{0, 0, 1, 1, 0, 0, 0, 1, 0};
        apply_reset();
        for (int i = 0; i < 9; i++) begin
            drive_edge(seq[i], 1'b0);
            num_checks++;
            if (dout !== expv[i]) begin
                num_fail++;
                $display("[TB] FAIL overlap edge %0d: dout=%b expected=%b", i, dout, expv[i]);
            end
        end
    endtask

    task automatic test_no_false_detect();
        bit seq[6];
        seq = '{1, 1, 0, 1, 1, 0};
        apply_reset();
        for (int i = 0; i < 6; i++) begin
            drive_edge(seq[i], 1'b0);
            num_checks++;
            if (dout !== 1'b0) begin
                num_fail++;
                $display("[TB] FAIL no_false edge %0d: dout=%b expected=0", i, dout);
            end
        end
    endtask

    task automatic test_saturation();
        bit expv[8];
        expv = '{0, 0, 1, 1, 1, 1, 1, 1};
        apply_reset();
        for (int i = 0; i < 8; i++) begin
            drive_edge(1'b1, 1'b0);
            num_checks++;
            if (dout !== expv[i]) begin
                num_fail++;
                $display("[TB] FAIL saturation edge %0d: dout=%b expected=%b", i, dout, expv[i]);
            end
        end
        drive_edge(1'b0, 1'b0);
        num_checks++;
        if (dout !== 1'b0) begin
            num_fail++;
            $display("[TB] FAIL saturation_fall: dout=%b expected=0", dout);
        end
    endtask

    task automatic test_mid_reset();
        bit seq[6];
        bit rsts[6];
        bit expv[6];
        seq  = '{1, 1, 1, 1, 1, 1};
        rsts = '{0, 0, 1, 0, 0, 0};
        expv = '{0, 0, 0, 0, 0, 1};
        apply_reset();
        for (int i = 0; i < 6; i++) begin
            drive_edge(seq[i], rsts[i]);
            num_checks++;
            if (dout !== expv[i]) begin
                num_fail++;
                $display("[TB] FAIL mid_reset edge %0d: dout=%b expected=%b", i, dout, expv[i]);
            end
        end
    endtask

    task automatic test_x_input();
        logic seq[6];
        bit expv[6];
        seq  = '{1'b1, 1'b1, 1'bx, 1'b1, 1'b1, 1'b1};
        expv = '{0, 0, 0, 0, 0, 1};
        apply_reset();
        for (int i = 0; i < 6; i++) begin
            drive_edge(seq[i], 1'b0);
            num_checks++;
            if (dout !== expv[i]) begin
                num_fail++;
                $display("[TB] FAIL x_input edge %0d: dout=%b expected=%b", i, dout, expv[i]);
            end
        end
    endtask

    initial begin
        num_checks = 0;
        num_fail   = 0;
        rst        = 1'b1;
        din        = 1'b0;
        test_reset();
        test_basic();
        test_overlap();
        test_no_false_detect();
        test_saturation();
        test_mid_reset();
        test_x_input();
        $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fail);
        $finish;
    end

endmodule
